// File: rtl/booth_pkg.sv
// Shared constants and types for the Booth multiplier result path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Holds the default product/word geometry, the helpers used to derive the
// word count and index width from arbitrary PROD_W/WORD_W, and the
// serializer state type.
package booth_pkg;

  localparam int PROD_W_DEF = 818;
  localparam int WORD_W_DEF = 64;

  // Integer ceiling division, usable in constant expressions.
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Index width for n words; never collapses to zero bits.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NWORDS          = ceil_div(PROD_W_DEF, WORD_W_DEF);
  localparam int IDX_W           = idx_width(NWORDS);
  localparam int LAST_VALID_BITS = PROD_W_DEF - (NWORDS - 1) * WORD_W_DEF;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/booth_result_serializer.sv
// Captures finished Booth products and streams them out LSW-first as WORD_W words.
// Latency: strobe at cycle T gives word_valid_o at T+1; back-to-back products have no bubble.
// Backpressure: word_ready_i stalls the stream; one product is buffered, a further one is dropped (overrun_o).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   prod_i/prod_valid_i product and single-cycle completion strobe
//   word_o/word_valid_o/word_ready_i  output word stream (valid/ready)
//   word_last_o         final word of the product
//   word_idx_o          word index, 0 = least significant
//   overrun_o           sticky: a product was dropped
//
// Build option: BOOTH_SER_SIGN_EXT_EN -- pad bits of the last word carry the
// product sign instead of zero.
module booth_result_serializer
  import booth_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int WORD_W = WORD_W_DEF,
  localparam int N_WORDS   = ceil_div(PROD_W, WORD_W),
  localparam int W_IDX     = idx_width(N_WORDS),
  localparam int LAST_BITS = PROD_W - (N_WORDS - 1) * WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PROD_W-1:0] prod_i,
  input  logic              prod_valid_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_valid_o,
  input  logic              word_ready_i,
  output logic              word_last_o,
  output logic [W_IDX-1:0]  word_idx_o,
  output logic              overrun_o
);

  localparam logic [W_IDX-1:0]  LAST_IDX  = W_IDX'(N_WORDS - 1);
  // Ones over the bits of the last word that carry real product data.
  localparam logic [WORD_W-1:0] LAST_MASK = {WORD_W{1'b1}} >> (WORD_W - LAST_BITS);

  state_e            state_q, state_d;
  logic [PROD_W-1:0] sh_q, sh_d;
  logic [PROD_W-1:0] pend_q, pend_d;
  logic              pend_full_q, pend_full_d;
  logic [W_IDX-1:0]  idx_q, idx_d;
  logic              overrun_q, overrun_d;

  logic              send;
  logic              xfer;
  logic              is_last;
  logic              prod_taken;
  logic [WORD_W-1:0] pad_bits;

`ifdef BOOTH_SER_SIGN_EXT_EN
  // Sign of the product in sh_q; its MSB is shifted away before the last word.
  logic sign_q, sign_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      idx_q       <= '0;
      overrun_q   <= 1'b0;
`ifdef BOOTH_SER_SIGN_EXT_EN
      sign_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      idx_q       <= idx_d;
      overrun_q   <= overrun_d;
`ifdef BOOTH_SER_SIGN_EXT_EN
      sign_q      <= sign_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    idx_d       = idx_q;
    overrun_d   = overrun_q;
    prod_taken  = 1'b0;
`ifdef BOOTH_SER_SIGN_EXT_EN
    sign_d      = sign_q;
`endif

    send    = (state_q == SEND);
    xfer    = send && word_ready_i;
    is_last = (idx_q == LAST_IDX);

    case (state_q)
      IDLE: begin
        if (prod_valid_i) begin
          sh_d       = prod_i;
          idx_d      = '0;
          state_d    = SEND;
          prod_taken = 1'b1;
`ifdef BOOTH_SER_SIGN_EXT_EN
          sign_d     = prod_i[PROD_W-1];
`endif
        end
      end
      SEND: begin
        if (xfer) begin
          if (!is_last) begin
            sh_d  = sh_q >> WORD_W;
            idx_d = idx_q + W_IDX'(1);
          end else if (pend_full_q) begin
            // Pending product follows immediately; frees the slot this cycle.
            sh_d        = pend_q;
            pend_full_d = 1'b0;
            idx_d       = '0;
`ifdef BOOTH_SER_SIGN_EXT_EN
            sign_d      = pend_q[PROD_W-1];
`endif
          end else if (prod_valid_i) begin
            sh_d       = prod_i;
            idx_d      = '0;
            prod_taken = 1'b1;
`ifdef BOOTH_SER_SIGN_EXT_EN
            sign_d     = prod_i[PROD_W-1];
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A strobe not loaded straight into the shifter goes to the pending slot.
    // pend_full_d already reflects a slot freed by a last-word transfer this
    // cycle, so that case refills it instead of dropping.
    if (prod_valid_i && !prod_taken) begin
      if (!pend_full_d) begin
        pend_d      = prod_i;
        pend_full_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

`ifdef BOOTH_SER_SIGN_EXT_EN
  assign pad_bits = sign_q ? ~LAST_MASK : '0;
`else
  assign pad_bits = '0;
`endif

  always_comb begin
    word_o = '0;
    if (send) begin
      word_o = is_last ? ((sh_q[WORD_W-1:0] & LAST_MASK) | pad_bits) : sh_q[WORD_W-1:0];
    end
  end

  assign word_valid_o = send;
  assign word_idx_o   = send ? idx_q : '0;
  assign word_last_o  = send && is_last;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_booth_result_serializer.sv
module tb_booth_result_serializer;

  localparam int PROD_W = 818;
  localparam int WORD_W = 64;
  localparam int NW     = 13;
  localparam int LVB    = 50;

`ifdef BOOTH_SER_SIGN_EXT_EN
  localparam bit SIGN_EXT = 1'b1;
`else
  localparam bit SIGN_EXT = 1'b0;
`endif

  typedef struct packed {
    logic              last;
    logic [3:0]        idx;
    logic [WORD_W-1:0] w;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [PROD_W-1:0] prod_i;
  logic              prod_valid_i;
  logic [WORD_W-1:0] word_o;
  logic              word_valid_o;
  logic              word_ready_i;
  logic              word_last_o;
  logic [3:0]        word_idx_o;
  logic              overrun_o;

  int checks = 0;
  int passed = 0;
  int words_seen = 0;

  exp_t              sb[$];
  logic [PROD_W-1:0] pq[$];

  booth_result_serializer dut (
    .clk          (clk),
    .rst          (rst),
    .prod_i       (prod_i),
    .prod_valid_i (prod_valid_i),
    .word_o       (word_o),
    .word_valid_o (word_valid_o),
    .word_ready_i (word_ready_i),
    .word_last_o  (word_last_o),
    .word_idx_o   (word_idx_o),
    .overrun_o    (overrun_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [831:0] obs, input logic [831:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [WORD_W-1:0] exp_word(input logic [PROD_W-1:0] p, input int k);
    logic [PROD_W-1:0] t;
    logic [WORD_W-1:0] w;
    t = p >> (k * WORD_W);
    w = t[WORD_W-1:0];
    if (k == NW - 1) begin
      for (int b = LVB; b < WORD_W; b++) w[b] = SIGN_EXT ? p[PROD_W-1] : 1'b0;
    end
    return w;
  endfunction

  task automatic push_prod(input logic [PROD_W-1:0] p);
    exp_t e;
    for (int k = 0; k < NW; k++) begin
      e.last = (k == NW - 1);
      e.idx  = 4'(k);
      e.w    = exp_word(p, k);
      sb.push_back(e);
    end
    pq.push_back(p);
  endtask

  function automatic logic [PROD_W-1:0] rand_prod();
    logic [831:0] t;
    for (int i = 0; i < 26; i++) t[i*32 +: 32] = $urandom;
    return t[PROD_W-1:0];
  endfunction

  // Output monitor: scoreboard compare, reassembly, stall stability.
  logic [831:0]      recon;
  logic              stall_prev = 1'b0;
  logic [68:0]       stall_snap;
  always @(negedge clk) begin
    exp_t e;
    logic [PROD_W-1:0] p;
    if (rst) begin
      sb.delete();
      pq.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        chk("stall_hold", {word_valid_o, word_last_o, word_idx_o, word_o}, {1'b1, stall_snap});
      stall_prev = 1'b0;
      if (word_valid_o && word_ready_i) begin
        words_seen++;
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("word", {word_last_o, word_idx_o, word_o}, e);
          recon[e.idx*WORD_W +: WORD_W] = word_o;
          if (e.last && pq.size() != 0) begin
            p = pq.pop_front();
            chk("reassembled", recon[PROD_W-1:0], p);
          end
        end
      end else if (word_valid_o) begin
        stall_prev = 1'b1;
        stall_snap = {word_last_o, word_idx_o, word_o};
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input bit rnd, input int max_cyc);
    for (int c = 0; c < max_cyc; c++) begin
      if (sb.size() == 0 && !word_valid_o) break;
      step();
      word_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    chk("drain_done", {sb.size() == 0, word_valid_o}, {1'b1, 1'b0});
  endtask

  initial begin
    logic [PROD_W-1:0] p;
    int gaps;
    int base;
    logic [13:0] exp_pad;

    rst = 1'b1;
    prod_i = '0;
    prod_valid_i = 1'b0;
    word_ready_i = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset state
    chk("reset_outs", {word_valid_o, word_last_o, word_idx_o, overrun_o, word_o},
        {1'b0, 1'b0, 4'd0, 1'b0, 64'd0});

    // Single product 1<<800, always ready: 13 contiguous words
    word_ready_i = 1'b1;
    p = '0;
    p[800] = 1'b1;
    prod_i = p;
    prod_valid_i = 1'b1;
    push_prod(p);
    base = words_seen;
    step();
    prod_valid_i = 1'b0;
    chk("latency_valid", {word_valid_o, word_idx_o}, {1'b1, 4'd0});
    gaps = 0;
    for (int k = 0; k < NW; k++) begin
      if (!word_valid_o) gaps++;
      step();
    end
    chk("single_contig", gaps, 0);
    chk("single_idle_after", word_valid_o, 1'b0);
    chk("single_count", words_seen - base, NW);

    // 100 random products with random consumer stalls
    for (int n = 0; n < 100; n++) begin
      p = rand_prod();
      prod_i = p;
      prod_valid_i = 1'b1;
      push_prod(p);
      step();
      prod_valid_i = 1'b0;
      word_ready_i = 1'($urandom_range(0, 1));
      drain(1'b1, 400);
    end

    // Strobes coinciding with the previous last word: no bubble
    word_ready_i = 1'b1;
    gaps = 0;
    for (int n = 0; n < 3; n++) begin
      p = rand_prod();
      prod_i = p;
      prod_valid_i = 1'b1;
      push_prod(p);
      step();
      prod_valid_i = 1'b0;
      if (!word_valid_o) gaps++;
      for (int k = 0; k < NW - 1; k++) begin
        step();
        if (!word_valid_o) gaps++;
      end
    end
    chk("b2b_no_bubble", gaps, 0);
    drain(1'b0, 100);
    chk("b2b_no_overrun", overrun_o, 1'b0);

    // Three consecutive strobes while stalled: third dropped
    word_ready_i = 1'b0;
    base = words_seen;
    for (int n = 0; n < 3; n++) begin
      p = rand_prod();
      prod_i = p;
      prod_valid_i = 1'b1;
      if (n < 2) push_prod(p);
      step();
    end
    prod_valid_i = 1'b0;
    chk("overrun_set", overrun_o, 1'b1);
    drain(1'b0, 100);
    chk("overrun_words", words_seen - base, 2 * NW);
    chk("overrun_sticky", overrun_o, 1'b1);

    // Negative product: last-word pad bits
    word_ready_i = 1'b1;
    p = rand_prod();
    p[PROD_W-1] = 1'b1;
    prod_i = p;
    prod_valid_i = 1'b1;
    push_prod(p);
    step();
    prod_valid_i = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (word_last_o) break;
      step();
    end
    exp_pad = SIGN_EXT ? 14'h3FFF : 14'h0;
    chk("sign_pad", {word_last_o, word_o[63:50]}, {1'b1, exp_pad});
    drain(1'b0, 50);

    // Reset mid-stream at word 5 with a product pending
    p = rand_prod();
    prod_i = p;
    prod_valid_i = 1'b1;
    push_prod(p);
    step();
    p = rand_prod();
    prod_i = p;
    push_prod(p);
    step();
    prod_valid_i = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (word_valid_o && word_idx_o == 4'd5) break;
      step();
    end
    chk("reached_word5", {word_valid_o, word_idx_o}, {1'b1, 4'd5});
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_outs", {word_valid_o, overrun_o, word_idx_o}, {1'b0, 1'b0, 4'd0});
    repeat (3) step();
    chk("rst_pending_gone", word_valid_o, 1'b0);
    p = rand_prod();
    prod_i = p;
    prod_valid_i = 1'b1;
    push_prod(p);
    step();
    prod_valid_i = 1'b0;
    chk("restart_idx0", {word_valid_o, word_idx_o}, {1'b1, 4'd0});
    drain(1'b0, 50);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
